// File: rtl/pc_sequencer.sv
// Program-counter sequencer: reset/hold/load/branch/call/ret/+STEP next-PC select.
// Define PC_RAS_EN to add a circular return-address stack for call/ret.
module pc_sequencer #(
  parameter int WIDTH = 16,
  parameter int unsigned STEP = 1,
  parameter int OFF_W = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             load,
  input  logic [WIDTH-1:0] target,
  input  logic             branch,
  input  logic [OFF_W-1:0] offset,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc,
  output logic             wrapped,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  if (WIDTH < 4 || WIDTH > 32 || OFF_W < 2 || OFF_W > WIDTH ||
      RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_bad_cfg
    $error("pc_sequencer: illegal parameter set");
  end

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] pc_d;
  logic             wrap_d;
  logic             uf_d;

  assign sum     = {1'b0, pc} + (WIDTH+1)'(STEP);
  assign pc_inc  = sum[WIDTH-1:0];
  assign off_ext = WIDTH'($signed(offset));

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_m1;
  logic [PW:0]      cnt;
  logic             push;
  logic             pop;

  assign sp_m1     = sp - PW'(1);
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == (PW+1)'(RAS_DEPTH));

  always_comb begin
    pc_d   = pc;
    wrap_d = 1'b0;
    uf_d   = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    if (stall) begin
      pc_d = pc;
    end else if (load) begin
      pc_d = target;
    end else if (call) begin
      pc_d = target;
      push = 1'b1;
    end else if (ret) begin
      if (ras_empty) begin
        pc_d = pc_inc;
        uf_d = 1'b1;
      end else begin
        pc_d = ras[sp_m1];
        pop  = 1'b1;
      end
    end else if (branch) begin
      pc_d = pc + off_ext;
    end else begin
      pc_d   = pc_inc;
      wrap_d = sum[WIDTH];
    end
  end

  // sp addresses the next free slot; when full it also points at the
  // oldest entry, so a push simply overwrites it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push) begin
      ras[sp] <= pc_inc;
      sp      <= sp + PW'(1);
      if (!ras_full) cnt <= cnt + (PW+1)'(1);
    end else if (pop) begin
      sp  <= sp_m1;
      cnt <= cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ras_underflow <= 1'b0;
    else       ras_underflow <= uf_d;
  end
`else
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_underflow = 1'b0;

  always_comb begin
    pc_d   = pc;
    wrap_d = 1'b0;
    uf_d   = 1'b0;
    if (stall) begin
      pc_d = pc;
    end else if (load || call) begin
      pc_d = target;
    end else if (ret) begin
      pc_d   = pc_inc;
      wrap_d = sum[WIDTH];
    end else if (branch) begin
      pc_d = pc + off_ext;
    end else begin
      pc_d   = pc_inc;
      wrap_d = sum[WIDTH];
    end
  end

  logic unused_uf;
  assign unused_uf = uf_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      wrapped <= 1'b0;
    end else begin
      pc      <= pc_d;
      wrapped <= wrap_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed plan steps then random stimulus,
// two configurations checked against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, load, branch, call, ret;
  logic [15:0] target;
  logic [7:0]  offset;

  logic [15:0] p0, pi0;
  logic        wr0, e0, f0, uf0;
  logic [7:0]  p1, pi1;
  logic        wr1, e1, f1, uf1;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH(16), .STEP(1), .OFF_W(8),
    .RESET_VECTOR(16'h0100), .RAS_DEPTH(2)
  ) u_a (
    .clk(clk), .reset(reset), .stall(stall), .load(load),
    .target(target), .branch(branch), .offset(offset),
    .call(call), .ret(ret), .pc(p0), .pc_inc(pi0),
    .wrapped(wr0), .ras_empty(e0), .ras_full(f0),
    .ras_underflow(uf0)
  );

  pc_sequencer #(
    .WIDTH(8), .STEP(2), .OFF_W(4),
    .RESET_VECTOR(8'hF0), .RAS_DEPTH(4)
  ) u_b (
    .clk(clk), .reset(reset), .stall(stall), .load(load),
    .target(target[7:0]), .branch(branch), .offset(offset[3:0]),
    .call(call), .ret(ret), .pc(p1), .pc_inc(pi1),
    .wrapped(wr1), .ras_empty(e1), .ras_full(f1),
    .ras_underflow(uf1)
  );

  int cw[2]  = '{16, 8};
  int cst[2] = '{1, 2};
  int cow[2] = '{8, 4};
  int crv[2] = '{'h100, 'hF0};
  int cdp[2] = '{2, 4};

  int m_pc[2];
  bit m_wr[2];
  bit m_uf[2];
  int stk[2][$];

  task automatic model(int k);
    int mask, inc, o;
    mask = (1 << cw[k]) - 1;
    inc  = m_pc[k] + cst[k];
    m_wr[k] = 1'b0;
    m_uf[k] = 1'b0;
    if (reset) begin
      m_pc[k] = crv[k];
      stk[k].delete();
    end else if (stall) begin
      m_pc[k] = m_pc[k];
    end else if (load) begin
      m_pc[k] = int'(target) & mask;
    end else if (call) begin
`ifdef PC_RAS_EN
      stk[k].push_back(inc & mask);
      if (stk[k].size() > cdp[k]) void'(stk[k].pop_front());
`endif
      m_pc[k] = int'(target) & mask;
    end else if (ret) begin
`ifdef PC_RAS_EN
      if (stk[k].size() > 0) begin
        m_pc[k] = stk[k].pop_back();
      end else begin
        m_pc[k] = inc & mask;
        m_uf[k] = 1'b1;
      end
`else
      m_pc[k] = inc & mask;
      m_wr[k] = (inc > mask);
`endif
    end else if (branch) begin
      o = int'(offset) & ((1 << cow[k]) - 1);
      if (o >= (1 << (cow[k] - 1))) o = o - (1 << cow[k]);
      m_pc[k] = (m_pc[k] + o) & mask;
    end else begin
      m_pc[k] = inc & mask;
      m_wr[k] = (inc > mask);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int m0, m1;
    m0 = (1 << cw[0]) - 1;
    m1 = (1 << cw[1]) - 1;
    chk("a.pc", 32'(p0), m_pc[0]);
    chk("a.pc_inc", 32'(pi0), (m_pc[0] + cst[0]) & m0);
    chk("a.wrapped", 32'(wr0), 32'(m_wr[0]));
    chk("a.underflow", 32'(uf0), 32'(m_uf[0]));
    chk("b.pc", 32'(p1), m_pc[1]);
    chk("b.pc_inc", 32'(pi1), (m_pc[1] + cst[1]) & m1);
    chk("b.wrapped", 32'(wr1), 32'(m_wr[1]));
    chk("b.underflow", 32'(uf1), 32'(m_uf[1]));
`ifdef PC_RAS_EN
    chk("a.empty", 32'(e0), 32'(stk[0].size() == 0));
    chk("a.full", 32'(f0), 32'(stk[0].size() == cdp[0]));
    chk("b.empty", 32'(e1), 32'(stk[1].size() == 0));
    chk("b.full", 32'(f1), 32'(stk[1].size() == cdp[1]));
`else
    chk("a.empty", 32'(e0), 32'd1);
    chk("a.full", 32'(f0), 32'd0);
    chk("b.empty", 32'(e1), 32'd1);
    chk("b.full", 32'(f1), 32'd0);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check_all();
  endtask

  task automatic idle();
    {reset, stall, load, branch, call, ret} = '0;
  endtask

  task automatic do_load(logic [15:0] t);
    idle(); load = 1'b1; target = t; cyc(); idle();
  endtask

  task automatic do_call(logic [15:0] t);
    idle(); call = 1'b1; target = t; cyc(); idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1'b1; cyc(); idle();
  endtask

  initial begin
    logic [31:0] r;
    idle();
    target = '0;
    offset = '0;
    reset  = 1'b1;
    cyc();
    cyc();
    idle();
    repeat (3) cyc();

    do_load(16'hFFFE);
    repeat (3) cyc();

    do_load(16'h0010);
    branch = 1'b1; offset = 8'hF0; cyc(); idle();
    load = 1'b1; branch = 1'b1; target = 16'h1234; cyc(); idle();
    stall = 1'b1; load = 1'b1; target = 16'h5555; cyc(); idle();
    branch = 1'b1; offset = 8'h7F; cyc(); idle();

    do_load(16'h0010);
    do_call(16'h0200);
    do_call(16'h0300);
    do_ret();
    do_ret();
    do_ret();
    cyc();

    do_load(16'h0009);
    do_call(16'h000A);
    do_call(16'h000B);
    do_call(16'h000C);
    do_ret();
    do_ret();
    do_ret();
    cyc();

    do_call(16'h0400);
    reset = 1'b1; call = 1'b1; stall = 1'b1; target = 16'h0777;
    cyc();
    idle();
    cyc();

    for (int i = 0; i < 600; i++) begin
      r      = $urandom;
      reset  = (r[5:0] == 6'd0);
      stall  = (r[8:6] == 3'd0);
      load   = (r[11:9] == 3'd0);
      call   = (r[14:12] < 3'd2);
      ret    = (r[17:15] < 3'd2);
      branch = (r[20:18] < 3'd2);
      target = (r[21]) ? 16'hFFF0 | 16'($urandom_range(15)) : 16'($urandom);
      offset = 8'($urandom);
      cyc();
    end
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
